// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and FSM encoding for the 8N1 UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int c_default_divisor = 868;
   localparam int c_data_width      = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Brief    : Valid/ready byte stream between the receiver and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if;

   logic                             rx_valid;
   logic [uart_pkg::c_data_width-1:0] rx_data;
   logic                             rx_ready;

   modport master (
      output rx_valid,
      output rx_data,
      input  rx_ready
   );

   modport slave (
      input  rx_valid,
      input  rx_data,
      output rx_ready
   );

endinterface : uart_rx_if
`default_nettype wire

// File: rtl/uart_rx_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_fifo
// Brief    : First-word fall-through byte FIFO, register-array storage.
// Revision : 1.0 - initial release
// ============================================================================
module byte_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_LOG2 = 4
) (
   input  wire logic                    clock,
   input  wire logic                    reset,
   input  wire logic                    i_push,
   input  wire logic [c_data_width-1:0] i_din,
   output logic                         o_full,
   input  wire logic                    i_pop,
   output logic [c_data_width-1:0]      o_dout,
   output logic                         o_empty
);

   localparam int c_depth = 1 << FIFO_LOG2;

   logic [c_data_width-1:0] r_mem [c_depth];
   logic [FIFO_LOG2:0]      r_wr_ptr;
   logic [FIFO_LOG2:0]      r_rd_ptr;
   logic                    w_do_push;
   logic                    w_do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[FIFO_LOG2] != r_rd_ptr[FIFO_LOG2]) &&
                    (r_wr_ptr[FIFO_LOG2-1:0] == r_rd_ptr[FIFO_LOG2-1:0]);

   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   assign o_dout = r_mem[r_rd_ptr[FIFO_LOG2-1:0]];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < c_depth; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[FIFO_LOG2-1:0]] <= i_din;
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
      end
   end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling 8N1 receiver with FIFO-buffered valid/ready output.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
   import uart_pkg::*;
#(
   parameter int DIVISOR   = c_default_divisor,
   parameter int FIFO_LOG2 = 4
) (
   input  wire logic  clock,
   input  wire logic  reset,
   input  wire logic  rxd,
   uart_rx_if.master  rx_bus,
   output logic       framing_error,
   output logic       overrun
);

   localparam int                 c_cnt_w = $clog2(DIVISOR);
   localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(DIVISOR / 2 - 1);
   localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DIVISOR - 1);

   logic                    r_sync1;
   logic                    r_rs;
   rx_state_t               r_state;
   logic [c_cnt_w-1:0]      r_cnt;
   logic [2:0]              r_idx;
   logic [c_data_width-1:0] r_shift;

   logic                    w_sample;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   logic [c_data_width-1:0] w_dout;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b1;
         r_rs    <= 1'b1;
      end else begin
         r_sync1 <= rxd;
         r_rs    <= r_sync1;
      end
   end

   assign w_sample = (r_cnt == '0);
   assign w_pop    = rx_bus.rx_valid && rx_bus.rx_ready;
   // Push is taken from the stop-sample cycle itself so the FIFO sees it on the same edge.
   assign w_push   = (r_state == ST_STOP) && w_sample && r_rs;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_shift       <= '0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         framing_error <= 1'b0;
         overrun       <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (!r_rs) begin
                  r_state <= ST_START;
                  r_cnt   <= c_half;
               end
            end
            ST_START: begin
               if (w_sample) begin
                  if (r_rs) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_DATA;
                     r_cnt   <= c_full;
                     r_idx   <= '0;
                  end
               end else begin
                  r_cnt <= r_cnt - c_cnt_w'(1);
               end
            end
            ST_DATA: begin
               if (w_sample) begin
                  r_shift[r_idx] <= r_rs;
                  r_cnt          <= c_full;
                  if (r_idx == 3'd7) begin
                     r_state <= ST_STOP;
                  end else begin
                     r_idx <= r_idx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt - c_cnt_w'(1);
               end
            end
            ST_STOP: begin
               // Leaving at mid-stop-bit leaves half a bit of margin for the next start edge.
               if (w_sample) begin
                  if (r_rs) begin
                     r_state <= ST_IDLE;
                     overrun <= w_full && !w_pop;
                  end else begin
                     r_state       <= ST_BREAK;
                     framing_error <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - c_cnt_w'(1);
               end
            end
            ST_BREAK: begin
               if (r_rs) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   byte_fifo #(
      .FIFO_LOG2 (FIFO_LOG2)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (w_push),
      .i_din   (r_shift),
      .o_full  (w_full),
      .i_pop   (w_pop),
      .o_dout  (w_dout),
      .o_empty (w_empty)
   );

   assign rx_bus.rx_valid = !w_empty;
   assign rx_bus.rx_data  = w_dout;

endmodule : uart_rx
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that sits directly upstream of the host-interface byte stream.
- Oversamples the asynchronous host RXD line and deframes 8N1 characters.
- Buffers received bytes in a small FIFO and presents them on a valid/ready byte interface that drives the htif rx_valid/rx_data/rx_ready ports.
- Reports framing errors and FIFO overruns as single-cycle pulses.

Parameters:
- DIVISOR, 868, clock cycles per bit (100 MHz / 115200 baud); legal range >= 4.
- FIFO_LOG2, 4, log2 of FIFO depth (default depth 16).

Ports:
- clock  input  1  system clock, all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- rxd  input  1  raw serial line; idle high; asynchronous to clock.
- rx_ready  input  1  consumer accepts the head byte this cycle.
- rx_valid  output  1  FIFO non-empty; head byte available.
- rx_data  output  8  head byte; meaningful only while rx_valid.
- framing_error  output  1  one-cycle pulse when a stop bit is sampled low.
- overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
- Reset state:
  - Asynchronous reset, active-high.
  - Synchronizer flops = 1; FSM = IDLE; counters = 0; FIFO empty.
  - rx_valid = 0, framing_error = 0, overrun = 0, rx_data = 0.
- Input synchronization: rxd passes through a 2-flop synchronizer. All sampling uses the synchronized value rs.
- Counter: bit counter width clog2(DIVISOR); bit index is 3 bits.
- IDLE:
  - rs == 0 -> go to START, load counter with DIVISOR/2 - 1 (integer division).
- START (counter decrements each cycle; acts at 0):
  - rs == 1 -> glitch; return to IDLE, no pulse.
  - rs == 0 -> go to DATA, counter = DIVISOR - 1, index = 0.
- DATA:
  - At counter 0, shift rs into bit[index] (LSB first) and reload counter = DIVISOR - 1.
  - After index 7 -> go to STOP.
- STOP (at counter 0):
  - rs == 1: push byte into FIFO.
    - If FIFO is full and no pop this cycle, drop the byte and pulse overrun.
    - Go to IDLE.
  - rs == 0: pulse framing_error, discard byte, go to BREAK.
- BREAK: wait for rs == 1, then go to IDLE. A held-low line yields exactly one framing_error.
- Timing:
  - Stop sample occurs 9*DIVISOR + DIVISOR/2 cycles after IDLE sees rs == 0.
  - rx_valid rises the following cycle if the FIFO was empty.
  - Returning to IDLE mid-stop-bit lets back-to-back frames with 1 stop bit be received.
- FIFO:
  - First-word fall-through: rx_data = head entry, rx_valid = !empty.
  - Pop when rx_valid && rx_ready.
  - Simultaneous push and pop when full: both occur, occupancy unchanged, no overrun.
  - Simultaneous push and pop when empty: push only; byte visible the next cycle.
  - Pointers are FIFO_LOG2+1 bits and wrap naturally; full = MSBs differ and the rest are equal.
  - Byte order is strictly preserved.
- Consumer rule: rx_ready may be asserted while rx_valid = 0 with no effect. rx_data is stable while rx_valid && !rx_ready.
- Reset mid-frame: all state returns to reset values immediately. A partial frame is lost and no pulse is emitted.

Decomposition:
- Package uart_pkg:
  - FSM state encodings: IDLE, START, DATA, STOP, BREAK.
  - Default DIVISOR constant.
  - Data width constant 8.
- Sub-module byte_fifo (parameter FIFO_LOG2):
  - Interfaces: push/din/full, pop/dout/empty.
  - FWFT register-array storage.
  - Same clock and asynchronous reset.
- uart_rx contains the synchronizer, FSM, counters, and pulse generation.

Test Plan (bench uses DIVISOR=16, FIFO_LOG2=4, rx_ready=1 unless stated):
1. Send 0x55 then 0xA3 back-to-back, 1 stop bit -> rx_valid rises 153 cycles after each start edge reaches rs; rx_data = 0x55 then 0xA3; no pulses.
2. Glitch: rxd low for 4 cycles, then high -> FSM returns to IDLE; no rx_valid, no framing_error. A following 0x3C is received correctly.
3. Framing: send 0xA5 with stop bit 0, then hold rxd low 40 cycles, release, send 0x01 -> exactly one framing_error pulse, no 0xA5 byte, then 0x01 delivered.
4. Overrun: rx_ready=0, send bytes 0x00..0x10 (17 bytes) -> overrun pulses once on the 17th byte. Then set rx_ready=1 -> 0x00..0x0F drained in order, then rx_valid=0.
5. Full with simultaneous pop: fill 16 bytes, pulse rx_ready for one cycle exactly at the 17th stop sample -> no overrun; 16 bytes remain; the 17th is last in order.
6. Reset mid-frame: assert reset during DATA bit 4 of 0xFF -> rx_valid=0, FIFO empty immediately. After release, 0x5A is received intact with no stray pulse.
